// File: rtl/sdram_responder_pkg.sv
// Shared definitions for the SDRAM device model: command encodings,
// violation codes, mode register layout/defaults and burst column helpers.
package sdram_responder_pkg;

    // {RAS_N, CAS_N, WE_N} with CS_N low and CKE high.
    typedef enum logic [2:0] {
        CMD_LOAD_MODE  = 3'b000,
        CMD_REFRESH    = 3'b001,
        CMD_PRECHARGE  = 3'b010,
        CMD_ACTIVE     = 3'b011,
        CMD_WRITE      = 3'b100,
        CMD_READ       = 3'b101,
        CMD_BURST_TERM = 3'b110,
        CMD_NOP        = 3'b111
    } cmd_e;

    // Protocol violation codes reported on ERR_CODE (0 = none yet).
    localparam logic [2:0] ERR_NONE         = 3'd0;
    localparam logic [2:0] ERR_IDLE_BANK    = 3'd1;
    localparam logic [2:0] ERR_BANK_OPEN    = 3'd2;
    localparam logic [2:0] ERR_REFRESH_OPEN = 3'd3;
    localparam logic [2:0] ERR_MODE         = 3'd4;
    localparam logic [2:0] ERR_CKE          = 3'd5;

    // Mode register field positions within SDRAM_ADDR.
    localparam int MODE_BL_LSB  = 0;
    localparam int MODE_CL_LSB  = 4;
    localparam int MODE_WB_BIT  = 9;
    localparam int ADDR_A10_BIT = 10;

    localparam logic [2:0] CL_ENC_2 = 3'b010;
    localparam logic [2:0] CL_ENC_3 = 3'b011;

    // bl_code is log2(burst length); cl3 selects CAS latency 3 over 2.
    typedef struct packed {
        logic [1:0] bl_code;
        logic       cl3;
        logic       wr_single;
    } mode_t;

    localparam mode_t MODE_RESET = '{bl_code: 2'd0, cl3: 1'b0, wr_single: 1'b0};

    // Burst engine state; IDLE means no beats pending after this edge.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } burst_st_e;

    // Index of the last beat of a burst (BL-1).
    function automatic logic [2:0] burst_last(input logic [1:0] bl_code);
        logic [2:0] last;
        case (bl_code)
            2'd0:    last = 3'd0;
            2'd1:    last = 3'd1;
            2'd2:    last = 3'd3;
            default: last = 3'd7;
        endcase
        return last;
    endfunction

    // Column of beat k: low bits count and wrap inside the BL-aligned block.
    function automatic logic [8:0] burst_col(input logic [8:0] start,
                                             input logic [2:0] k,
                                             input logic [1:0] bl_code);
        logic [8:0] mask;
        mask = {6'd0, burst_last(bl_code)};
        return (start & ~mask) | ((start + {6'd0, k}) & mask);
    endfunction

endpackage

// File: rtl/sdram_read_pipe.sv
// CAS-latency delay line for read data. The input is the registered array
// read; one extra stage is inserted for CL=3. The final stage also captures
// the byte enables from the DQM value sampled one edge earlier and drives
// the DQ output enables.
module sdram_read_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        cl3,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic [1:0]  dqm_prev,
    output logic [15:0] dq_out,
    output logic [1:0]  dq_oe
);

    logic        mid_valid_d, mid_valid_q;
    logic [15:0] mid_data_d, mid_data_q;
    logic        out_valid_d, out_valid_q;
    logic [15:0] out_data_d, out_data_q;
    logic [1:0]  out_be_d, out_be_q;

    // Next values: the output stage bypasses the middle stage for CL=2.
    always_comb begin
        mid_valid_d = in_valid;
        mid_data_d  = in_data;
        out_valid_d = cl3 ? mid_valid_q : in_valid;
        out_data_d  = cl3 ? mid_data_q : in_data;
        out_be_d    = ~dqm_prev;
    end

    // Pipeline registers; reset empties the pipe and releases DQ at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            mid_valid_q <= 1'b0;
            mid_data_q  <= 16'h0000;
            out_valid_q <= 1'b0;
            out_data_q  <= 16'h0000;
            out_be_q    <= 2'b00;
        end else begin
            mid_valid_q <= mid_valid_d;
            mid_data_q  <= mid_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_be_q    <= out_be_d;
        end
    end

    // Per-byte output enables for the DQ tristate.
    always_comb begin
        dq_out = out_data_q;
        dq_oe  = {2{out_valid_q}} & out_be_q;
    end

endmodule

// File: rtl/sdram_responder.sv
// SDR SDRAM device model: command decoder, per-bank open-row table, mode
// register, burst engine with wrapping column generation, word array and
// protocol violation reporting. Read data leaves through sdram_read_pipe.
module sdram_responder
    import sdram_responder_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 12
) (
    input  logic        SDRAM_CLK,
    input  logic        RESET,
    input  logic        SDRAM_CKE,
    input  logic        SDRAM_CS_N,
    input  logic        SDRAM_RAS_N,
    input  logic        SDRAM_CAS_N,
    input  logic        SDRAM_WE_N,
    input  logic [1:0]  SDRAM_BA,
    input  logic [12:0] SDRAM_ADDR,
    input  logic [1:0]  SDRAM_DQM,
    inout  wire  [15:0] SDRAM_DQ,
    output logic        ERR_STB,
    output logic [2:0]  ERR_CODE
);

    localparam int DEPTH = 1 << MEM_ADDR_BITS;

    // Decoded command
    cmd_e       cmd;
    logic       cmd_valid;
    logic       rw_ok;
    logic       stop;
    logic       mode_ok;

    // Bank table, mode register, violation reporting
    logic [3:0]       bank_open_d, bank_open_q;
    logic [3:0][12:0] bank_row_d, bank_row_q;
    mode_t            mode_d, mode_q;
    logic             err_stb_d, err_stb_q;
    logic [2:0]       err_code_d, err_code_q;
    logic [2:0]       err_now;

    // Burst engine
    burst_st_e  st_d, st_q;
    logic [2:0] cnt_d, cnt_q;
    logic [1:0] burst_ba_d, burst_ba_q;
    logic [12:0] burst_row_d, burst_row_q;
    logic [8:0] burst_col_d, burst_col_q;
    logic [1:0] burst_bl_d, burst_bl_q;

    // Beat performed at this edge
    logic        beat_rd, beat_wr;
    logic [1:0]  beat_ba;
    logic [12:0] beat_row;
    logic [8:0]  beat_col;
    logic [MEM_ADDR_BITS-1:0] mem_idx;
    logic [1:0]  mem_we;

    // Array and read launch stage
    logic [15:0] mem_q [DEPTH];
    logic        rd_valid_d, rd_valid_q;
    logic [15:0] rd_data_d, rd_data_q;
    logic [1:0]  dqm_d, dqm_q;
    logic [15:0] dq_out;
    logic [1:0]  dq_oe;

    // Command decode; an accepted READ/WRITE or a terminating command ends any burst.
    always_comb begin
        cmd_valid = SDRAM_CKE && !SDRAM_CS_N;
        cmd       = cmd_e'({SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N});
        rw_ok     = cmd_valid && ((cmd == CMD_READ) || (cmd == CMD_WRITE))
                    && bank_open_q[SDRAM_BA];
        stop      = cmd_valid && ((cmd == CMD_BURST_TERM) ||
                    ((cmd == CMD_PRECHARGE) &&
                     (SDRAM_ADDR[ADDR_A10_BIT] || (SDRAM_BA == burst_ba_q))));
        mode_ok   = !SDRAM_ADDR[MODE_BL_LSB + 2] &&
                    ((SDRAM_ADDR[MODE_CL_LSB +: 3] == CL_ENC_2) ||
                     (SDRAM_ADDR[MODE_CL_LSB +: 3] == CL_ENC_3));
    end

    // Bank table, mode register and violation detection.
    always_comb begin
        bank_open_d = bank_open_q;
        bank_row_d  = bank_row_q;
        mode_d      = mode_q;
        err_now     = ERR_NONE;
        if (cmd_valid) begin
            case (cmd)
                CMD_ACTIVE: begin
                    if (bank_open_q[SDRAM_BA]) err_now = ERR_BANK_OPEN;
                    bank_open_d[SDRAM_BA] = 1'b1;
                    bank_row_d[SDRAM_BA]  = SDRAM_ADDR;
                end
                CMD_READ, CMD_WRITE: begin
                    if (!bank_open_q[SDRAM_BA]) err_now = ERR_IDLE_BANK;
                end
                CMD_PRECHARGE: begin
                    if (SDRAM_ADDR[ADDR_A10_BIT]) bank_open_d = 4'b0000;
                    else                          bank_open_d[SDRAM_BA] = 1'b0;
                end
                CMD_REFRESH: begin
                    if (|bank_open_q) err_now = ERR_REFRESH_OPEN;
                end
                CMD_LOAD_MODE: begin
                    if ((|bank_open_q) || !mode_ok) begin
                        err_now = ERR_MODE;
                    end else begin
                        mode_d.bl_code   = SDRAM_ADDR[MODE_BL_LSB +: 2];
                        mode_d.cl3       = (SDRAM_ADDR[MODE_CL_LSB +: 3] == CL_ENC_3);
                        mode_d.wr_single = SDRAM_ADDR[MODE_WB_BIT];
                    end
                end
                default: ;
            endcase
        end else if (!SDRAM_CKE && !SDRAM_CS_N && (cmd != CMD_NOP)) begin
            err_now = ERR_CKE;
        end
        err_stb_d  = (err_now != ERR_NONE);
        err_code_d = err_code_q;
        if (err_stb_d && (err_code_q == ERR_NONE)) err_code_d = err_now;
    end

    // Burst engine next state: new command first, then terminate, then continue.
    always_comb begin
        st_d        = st_q;
        cnt_d       = cnt_q;
        burst_ba_d  = burst_ba_q;
        burst_row_d = burst_row_q;
        burst_col_d = burst_col_q;
        burst_bl_d  = burst_bl_q;
        if (rw_ok) begin
            burst_ba_d  = SDRAM_BA;
            burst_row_d = bank_row_q[SDRAM_BA];
            burst_col_d = SDRAM_ADDR[8:0];
            burst_bl_d  = ((cmd == CMD_WRITE) && mode_q.wr_single) ? 2'd0 : mode_q.bl_code;
            cnt_d       = 3'd1;
            if (burst_bl_d == 2'd0)     st_d = ST_IDLE;
            else if (cmd == CMD_READ)   st_d = ST_READ;
            else                        st_d = ST_WRITE;
        end else if (stop) begin
            st_d = ST_IDLE;
        end else if (st_q != ST_IDLE) begin
            if (cnt_q == burst_last(burst_bl_q)) st_d = ST_IDLE;
            else                                 cnt_d = cnt_q + 3'd1;
        end
    end

    // Burst engine outputs: which beat (if any) happens at this edge and where.
    always_comb begin
        beat_rd  = 1'b0;
        beat_wr  = 1'b0;
        beat_ba  = burst_ba_q;
        beat_row = burst_row_q;
        beat_col = burst_col(burst_col_q, cnt_q, burst_bl_q);
        if (rw_ok) begin
            beat_rd  = (cmd == CMD_READ);
            beat_wr  = (cmd == CMD_WRITE);
            beat_ba  = SDRAM_BA;
            beat_row = bank_row_q[SDRAM_BA];
            beat_col = SDRAM_ADDR[8:0];
        end else if (!stop) begin
            beat_rd = (st_q == ST_READ);
            beat_wr = (st_q == ST_WRITE);
        end
        mem_idx    = MEM_ADDR_BITS'({beat_ba, beat_row, beat_col});
        mem_we     = (beat_wr && !RESET) ? ~SDRAM_DQM : 2'b00;
        rd_valid_d = beat_rd;
        rd_data_d  = mem_q[mem_idx];
        dqm_d      = SDRAM_DQM;
    end

    // Control state registers.
    always_ff @(posedge SDRAM_CLK) begin
        if (RESET) begin
            bank_open_q <= 4'b0000;
            bank_row_q  <= '0;
            mode_q      <= MODE_RESET;
            err_stb_q   <= 1'b0;
            err_code_q  <= ERR_NONE;
            st_q        <= ST_IDLE;
            cnt_q       <= 3'd0;
            burst_ba_q  <= 2'd0;
            burst_row_q <= 13'd0;
            burst_col_q <= 9'd0;
            burst_bl_q  <= 2'd0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= 16'h0000;
            dqm_q       <= 2'b00;
        end else begin
            bank_open_q <= bank_open_d;
            bank_row_q  <= bank_row_d;
            mode_q      <= mode_d;
            err_stb_q   <= err_stb_d;
            err_code_q  <= err_code_d;
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            burst_ba_q  <= burst_ba_d;
            burst_row_q <= burst_row_d;
            burst_col_q <= burst_col_d;
            burst_bl_q  <= burst_bl_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            dqm_q       <= dqm_d;
        end
    end

    // Byte-masked array write from the DQ pins.
    always_ff @(posedge SDRAM_CLK) begin
        if (mem_we[1]) mem_q[mem_idx][15:8] <= SDRAM_DQ[15:8];
        if (mem_we[0]) mem_q[mem_idx][7:0]  <= SDRAM_DQ[7:0];
    end

    sdram_read_pipe u_read_pipe (
        .clk      (SDRAM_CLK),
        .rst      (RESET),
        .cl3      (mode_q.cl3),
        .in_valid (rd_valid_q),
        .in_data  (rd_data_q),
        .dqm_prev (dqm_q),
        .dq_out   (dq_out),
        .dq_oe    (dq_oe)
    );

    assign SDRAM_DQ[15:8] = dq_oe[1] ? dq_out[15:8] : 8'hzz;
    assign SDRAM_DQ[7:0]  = dq_oe[0] ? dq_out[7:0]  : 8'hzz;

    assign ERR_STB  = err_stb_q;
    assign ERR_CODE = err_code_q;

endmodule
